// File: rtl/leaky_accu_sched.sv
// Bank of leaky accumulators sharing one datapath. Pending events are granted
// round-robin one per cycle; a periodic sweep decrements each nonzero counter.
module leaky_accu_sched #(
  parameter int p_base_width = 6,
  parameter int p_channels   = 4,
  parameter int p_leak_div   = 16
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic [p_channels-1:0]                   i_event,
  output logic [p_channels*(p_base_width+3)-1:0]  o_ln,
  output logic [p_channels-1:0]                   o_clr,
  output logic [p_channels-1:0]                   o_drop,
  output logic                                    o_busy
);

  localparam int CW = p_base_width + 3;
  localparam int IW = $clog2(p_channels);
  localparam int AW = IW + 1;
  localparam int DW = (p_leak_div > 1) ? $clog2(p_leak_div) : 1;
  localparam logic [CW-1:0] INC = CW'({p_base_width{1'b1}});

  typedef enum logic {
    S_ACC  = 1'b0,
    S_LEAK = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q [p_channels];
  logic [CW-1:0]         cnt_d [p_channels];
  logic [p_channels-1:0] pend_q, pend_d;
  logic [p_channels-1:0] clr_q, clr_d;
  logic [p_channels-1:0] drop_q, drop_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         div_q, div_d;
  logic                  leak_pend_q, leak_pend_d;

  logic                  tick;
  logic                  sweep_start;
  logic                  gnt_vld;
  logic [IW-1:0]         gnt_idx;
  logic [p_channels-1:0] gnt;
  logic [AW-1:0]         cand;
  logic [CW:0]           sum;

  // Free-running leak divider, independent of the FSM state.
  always_comb begin
    tick  = (div_q == DW'(p_leak_div - 1));
    div_d = tick ? '0 : div_q + DW'(1);
  end

  // Round-robin search starting at ptr_q; only in S_ACC with no sweep waiting.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    cand    = '0;
    if (state_q == S_ACC && !leak_pend_q) begin
      for (int unsigned i = 0; i < p_channels; i++) begin
        cand = {1'b0, ptr_q} + AW'(i);
        if (cand >= AW'(p_channels)) cand = cand - AW'(p_channels);
        if (!gnt_vld && pend_q[cand[IW-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand[IW-1:0];
        end
      end
      if (gnt_vld) gnt[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    sweep_start = 1'b0;
    sum         = '0;

    case (state_q)
      S_ACC: begin
        if (leak_pend_q) begin
          state_d     = S_LEAK;
          idx_d       = '0;
          sweep_start = 1'b1;
        end else if (gnt_vld) begin
          ptr_d = (gnt_idx == IW'(p_channels - 1)) ? '0 : gnt_idx + IW'(1);
        end
      end
      S_LEAK: begin
        if (idx_q == IW'(p_channels - 1)) begin
          state_d = S_ACC;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
    endcase

    for (int unsigned k = 0; k < p_channels; k++) begin
      if (gnt[k]) begin
        sum      = {1'b0, cnt_q[k]} + {1'b0, INC};
        cnt_d[k] = sum[CW] ? '1 : sum[CW-1:0];
      end else if (state_q == S_LEAK && idx_q == IW'(k) && cnt_q[k] != '0) begin
        cnt_d[k] = cnt_q[k] - CW'(1);
      end
    end

    // A same-cycle grant and new event leave the channel pending without a drop.
    pend_d      = (pend_q & ~gnt) | i_event;
    drop_d      = pend_q & i_event & ~gnt;
    clr_d       = gnt;
    leak_pend_d = tick | (leak_pend_q & ~sweep_start);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_ACC;
      cnt_q       <= '{default: '0};
      pend_q      <= '0;
      clr_q       <= '0;
      drop_q      <= '0;
      ptr_q       <= '0;
      idx_q       <= '0;
      div_q       <= '0;
      leak_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      clr_q       <= clr_d;
      drop_q      <= drop_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      div_q       <= div_d;
      leak_pend_q <= leak_pend_d;
    end
  end

  always_comb begin
    o_ln = '0;
    for (int unsigned k = 0; k < p_channels; k++) begin
      o_ln[k*CW +: CW] = cnt_q[k];
    end
  end

  assign o_clr  = clr_q;
  assign o_drop = drop_q;
  assign o_busy = (state_q == S_LEAK);

endmodule

// File: tb/tb_leaky_accu_sched.sv
// Bench for leaky_accu_sched: directed scenarios with literal expectations,
// then random events, all compared every cycle against a behavioural model.
module tb_leaky_accu_sched;

  localparam int P   = 4;
  localparam int BW  = 6;
  localparam int CW  = BW + 3;
  localparam int DIV = 16;
  localparam int INC = (1 << BW) - 1;
  localparam int SAT = (1 << CW) - 1;

  logic              clk;
  logic              i_rst;
  logic [P-1:0]      i_event;
  logic [P*CW-1:0]   o_ln;
  logic [P-1:0]      o_clr;
  logic [P-1:0]      o_drop;
  logic              o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int           m_cnt [P];
  bit           m_pend [P];
  int           m_ptr;
  int           m_cycles;
  bit           m_lp;
  int           m_sweep;
  logic [P-1:0] e_clr;
  logic [P-1:0] e_drop;
  bit           e_busy;

  leaky_accu_sched #(
    .p_base_width(BW),
    .p_channels  (P),
    .p_leak_div  (DIV)
  ) dut (
    .i_clk  (clk),
    .i_rst  (i_rst),
    .i_event(i_event),
    .o_ln   (o_ln),
    .o_clr  (o_clr),
    .o_drop (o_drop),
    .o_busy (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ln(input int k);
    return int'(o_ln[k*CW +: CW]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs after one clock edge, derived from the behavioural rules.
  task automatic model_step(input logic [P-1:0] ev, input logic rst);
    int g;
    bit tick;
    if (rst) begin
      for (int k = 0; k < P; k++) begin
        m_cnt[k]  = 0;
        m_pend[k] = 0;
      end
      m_ptr = 0; m_cycles = 0; m_lp = 0; m_sweep = -1;
      e_clr = '0; e_drop = '0; e_busy = 0;
      return;
    end
    g = -1;
    m_cycles++;
    tick   = (m_cycles % DIV) == 0;
    e_clr  = '0;
    e_drop = '0;
    if (m_sweep >= 0) begin
      if (m_cnt[m_sweep] > 0) m_cnt[m_sweep]--;
      m_sweep++;
      if (m_sweep == P) m_sweep = -1;
    end else if (m_lp) begin
      m_lp    = 0;
      m_sweep = 0;
    end else begin
      for (int i = 0; i < P; i++) begin
        int k;
        k = (m_ptr + i) % P;
        if (g < 0 && m_pend[k]) g = k;
      end
    end
    for (int k = 0; k < P; k++) begin
      if (ev[k] && m_pend[k] && k != g) e_drop[k] = 1'b1;
      m_pend[k] = (m_pend[k] && k != g) || ev[k];
    end
    if (g >= 0) begin
      m_cnt[g] = (m_cnt[g] + INC > SAT) ? SAT : m_cnt[g] + INC;
      m_ptr    = (g + 1) % P;
      e_clr[g] = 1'b1;
    end
    if (tick) m_lp = 1;
    e_busy = (m_sweep >= 0);
  endtask

  task automatic check_model();
    for (int k = 0; k < P; k++) chk($sformatf("ln%0d", k), ln(k), m_cnt[k]);
    chk("clr",  int'(o_clr),  int'(e_clr));
    chk("drop", int'(o_drop), int'(e_drop));
    chk("busy", int'(o_busy), int'(e_busy));
  endtask

  // One clock: drive, advance the model, then compare away from the edge.
  task automatic cyc(input logic [P-1:0] ev, input logic rst);
    i_event = ev;
    i_rst   = rst;
    model_step(ev, rst);
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic wait_clr(input int k, input string nm);
    bit seen;
    seen = 0;
    for (int n = 0; n < 12 && !seen; n++) begin
      cyc('0, 1'b0);
      if (o_clr[k]) seen = 1;
    end
    chk(nm, int'(seen), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    int drop_rise;
    int clr2_cnt;
    bit prev_drop;
    logic [P-1:0] ev;

    i_event = '0;
    i_rst   = 1'b1;

    // 1: single event, two-edge latency to o_clr
    cyc('0, 1'b1);
    chk("t1_reset_ln0", ln(0), 0);
    chk("t1_reset_busy", int'(o_busy), 0);
    cyc('0, 1'b0);
    cyc(4'b0001, 1'b0);
    chk("t1_clr_early", int'(o_clr), 0);
    cyc('0, 1'b0);
    chk("t1_clr", int'(o_clr), 1);
    chk("t1_ln0", ln(0), 63);
    chk("t1_ln1", ln(1), 0);
    chk("t1_drop", int'(o_drop), 0);
    cyc('0, 1'b0);
    chk("t1_clr_after", int'(o_clr), 0);

    // 2: round-robin order from ptr=0, then from ptr=2
    cyc('0, 1'b1);
    cyc(4'b1111, 1'b0);
    for (int i = 0; i < P; i++) begin
      cyc('0, 1'b0);
      chk($sformatf("t2a_clr%0d", i), int'(o_clr), 1 << i);
      chk($sformatf("t2a_ln%0d", i), ln(i), 63);
    end
    cyc('0, 1'b1);
    cyc(4'b0010, 1'b0);
    cyc('0, 1'b0);
    cyc(4'b1111, 1'b0);
    for (int i = 0; i < P; i++) begin
      cyc('0, 1'b0);
      chk($sformatf("t2b_clr%0d", i), int'(o_clr), 1 << ((2 + i) % P));
    end

    // 3: leak sweep length and drain to zero
    cyc('0, 1'b1);
    cyc(4'b0001, 1'b0);
    cyc('0, 1'b0);
    chk("t3_ln0_init", ln(0), 63);
    busy_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      cyc('0, 1'b0);
      if (o_busy) busy_cnt++;
    end
    chk("t3_busy_len", busy_cnt, 4);
    chk("t3_ln0_leak", ln(0), 62);
    for (int n = 0; n < 1100; n++) cyc('0, 1'b0);
    chk("t3_ln0_zero", ln(0), 0);
    for (int n = 0; n < 40; n++) cyc('0, 1'b0);
    chk("t3_ln0_still_zero", ln(0), 0);

    // 4: saturation on channel 1
    cyc('0, 1'b1);
    for (int p = 0; p < 9; p++) begin
      cyc(4'b0010, 1'b0);
      wait_clr(1, $sformatf("t4_grant%0d", p));
      cyc('0, 1'b0);
    end
    chk("t4_ln1_sat", ln(1), SAT);

    // 5: held event on a pending channel drops once, accumulates once
    cyc('0, 1'b1);
    drop_rise = 0; clr2_cnt = 0; prev_drop = 0;
    for (int n = 0; n < 9; n++) begin
      ev = (n == 0) ? 4'b0111 : (n < 3) ? 4'b0100 : 4'b0000;
      cyc(ev, 1'b0);
      if (o_drop[2] && !prev_drop) drop_rise++;
      prev_drop = o_drop[2];
      if (o_clr[2]) clr2_cnt++;
    end
    chk("t5_drop_pulses", drop_rise, 1);
    chk("t5_clr2_count", clr2_cnt, 1);
    chk("t5_ln2", ln(2), 63);

    // 6: reset during a sweep with an event pending
    cyc('0, 1'b1);
    cyc(4'b0001, 1'b0);
    for (int n = 0; n < 30 && !o_busy; n++) cyc('0, 1'b0);
    chk("t6_busy_seen", int'(o_busy), 1);
    cyc(4'b1000, 1'b0);
    cyc('0, 1'b1);
    chk("t6_ln0", ln(0), 0);
    chk("t6_busy", int'(o_busy), 0);
    for (int n = 0; n < 3; n++) begin
      cyc('0, 1'b0);
      chk("t6_no_clr", int'(o_clr), 0);
    end

    // Random: dense events, then sparse events so counters drain
    cyc('0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < P; k++) begin
        if (n < 1500) ev[k] = 1'($urandom_range(0, 1));
        else          ev[k] = ($urandom_range(0, 31) == 0);
      end
      cyc(ev, ($urandom_range(0, 499) == 0));
    end
    for (int n = 0; n < 200; n++) cyc('0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
